// File: rtl/exception_sequencer.sv
// exception_sequencer: multicycle controller that takes over the datapath
// selects to service an invalid-opcode or ALU-overflow exception.
// Sequence: EPC <- PC - 4, fetch the vector word at 252, then load PC from
// the cause byte (254 for opcode, 255 for overflow).
// Every output is a register that is loaded together with the next state, so
// no combinational path exists from the request inputs to any output.
module exception_sequencer #(
    parameter int         MEM_LAT      = 1,
    parameter logic [2:0] ALU_SUB      = 3'd2,
    parameter logic [3:0] SEL_PC_A     = 4'd0,
    parameter logic [3:0] SEL_FOUR_B   = 4'd1,
    parameter logic [3:0] SEL_VEC_ADDR = 4'd2,
    parameter logic [3:0] SEL_TREAT_PC = 4'd3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       opc_exc,
    input  logic       ovf_exc,
    output logic       busy,
    output logic [3:0] alu_src_a,
    output logic [3:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [3:0] iord,
    output logic [3:0] pc_source,
    output logic       treat_src,
    output logic       epc_write,
    output logic       pc_write,
    output logic       mem_wr,
    output logic       cause,
    output logic       done,
    output logic [7:0] exc_count,
    output logic       double_fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EPC   = 3'd1,
        S_FETCH = 3'd2,
        S_WAIT  = 3'd3,
        S_LOAD  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic       busy;
        logic [3:0] alu_src_a;
        logic [3:0] alu_src_b;
        logic [2:0] alu_op;
        logic [3:0] iord;
        logic [3:0] pc_source;
        logic       treat_src;
        logic       epc_write;
        logic       pc_write;
        logic       done;
    } ctl_t;

    state_t     state;
    ctl_t       ctl;
    logic [2:0] wait_cnt;
    logic       cause_r;
    logic [7:0] exc_count_r;
    logic       double_fault_r;

    // Select/enable pattern the sequencer drives while sitting in state s.
    function automatic ctl_t decode(state_t s, logic cs);
        ctl_t c;
        c = '0;
        case (s)
            S_EPC: begin
                c.busy      = 1'b1;
                c.alu_src_a = SEL_PC_A;
                c.alu_src_b = SEL_FOUR_B;
                c.alu_op    = ALU_SUB;
                c.epc_write = 1'b1;
            end
            S_FETCH, S_WAIT: begin
                c.busy = 1'b1;
                c.iord = SEL_VEC_ADDR;
            end
            S_LOAD: begin
                c.busy      = 1'b1;
                c.iord      = SEL_VEC_ADDR;
                c.treat_src = cs;
                c.pc_source = SEL_TREAT_PC;
                c.pc_write  = 1'b1;
            end
            S_DONE: begin
                c.busy = 1'b1;
                c.done = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Sequencer FSM: advances state and loads the matching registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            ctl            <= '0;
            wait_cnt       <= '0;
            cause_r        <= 1'b0;
            exc_count_r    <= '0;
            double_fault_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (opc_exc || ovf_exc) begin
                        // Opcode wins a tie, so cause is 1 only for a lone overflow.
                        cause_r <= ~opc_exc;
                        state   <= S_EPC;
                        ctl     <= decode(S_EPC, ~opc_exc);
                    end else begin
                        state <= S_IDLE;
                        ctl   <= decode(S_IDLE, cause_r);
                    end
                end
                S_EPC: begin
                    state <= S_FETCH;
                    ctl   <= decode(S_FETCH, cause_r);
                end
                S_FETCH: begin
                    wait_cnt <= 3'(MEM_LAT);
                    if (MEM_LAT == 0) begin
                        state <= S_LOAD;
                        ctl   <= decode(S_LOAD, cause_r);
                    end else begin
                        state <= S_WAIT;
                        ctl   <= decode(S_WAIT, cause_r);
                    end
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 3'd1;
                    // <= 1 rather than == 1 so a corrupted zero count cannot stall.
                    if (wait_cnt <= 3'd1) begin
                        state <= S_LOAD;
                        ctl   <= decode(S_LOAD, cause_r);
                    end else begin
                        state <= S_WAIT;
                        ctl   <= decode(S_WAIT, cause_r);
                    end
                end
                S_LOAD: begin
                    state <= S_DONE;
                    ctl   <= decode(S_DONE, cause_r);
                    if (exc_count_r != 8'hFF)
                        exc_count_r <= exc_count_r + 8'd1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    ctl   <= decode(S_IDLE, cause_r);
                end
                default: begin
                    state <= S_IDLE;
                    ctl   <= '0;
                end
            endcase
            // A request seen while servicing is dropped but remembered.
            if (ctl.busy && (opc_exc || ovf_exc))
                double_fault_r <= 1'b1;
        end
    end

    assign busy         = ctl.busy;
    assign alu_src_a    = ctl.alu_src_a;
    assign alu_src_b    = ctl.alu_src_b;
    assign alu_op       = ctl.alu_op;
    assign iord         = ctl.iord;
    assign pc_source    = ctl.pc_source;
    assign treat_src    = ctl.treat_src;
    assign epc_write    = ctl.epc_write;
    assign pc_write     = ctl.pc_write;
    assign done         = ctl.done;
    assign mem_wr       = 1'b0;
    assign cause        = cause_r;
    assign exc_count    = exc_count_r;
    assign double_fault = double_fault_r;

endmodule

// File: tb/tb_exception_sequencer.sv
// Testbench for exception_sequencer: two instances (MEM_LAT = 0 and 1) checked
// every cycle against a timeline model, plus a directed vector table and
// hand-written corner sequences.
module tb_exception_sequencer;

    typedef struct packed {
        logic       busy;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] iord;
        logic [3:0] pcs;
        logic       treat;
        logic       epcw;
        logic       pcw;
        logic       memwr;
        logic       done;
        logic       cause;
        logic [7:0] cnt;
        logic       df;
    } obs_t;

    typedef struct {
        bit   opc;
        bit   ovf;
        obs_t exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic opc0 = 1'b0, ovf0 = 1'b0, opc1 = 1'b0, ovf1 = 1'b0;

    logic       busy0, busy1, treat0, treat1, epcw0, epcw1, pcw0, pcw1;
    logic       memwr0, memwr1, cause0, cause1, done0, done1, df0, df1;
    logic [3:0] a0, a1, b0, b1, iord0, iord1, pcs0, pcs1;
    logic [2:0] op0, op1;
    logic [7:0] cnt0, cnt1;
    obs_t       act0, act1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: k = cycles since the request was accepted (0 = idle).
    int k[2];
    int lat[2];
    int cause_m[2];
    int cnt_m[2];
    int df_m[2];

    always #5 clock = ~clock;

    exception_sequencer #(.MEM_LAT(0)) u_dut0 (
        .clock(clock), .reset(reset), .opc_exc(opc0), .ovf_exc(ovf0),
        .busy(busy0), .alu_src_a(a0), .alu_src_b(b0), .alu_op(op0), .iord(iord0),
        .pc_source(pcs0), .treat_src(treat0), .epc_write(epcw0), .pc_write(pcw0),
        .mem_wr(memwr0), .cause(cause0), .done(done0), .exc_count(cnt0),
        .double_fault(df0)
    );

    exception_sequencer #(.MEM_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .opc_exc(opc1), .ovf_exc(ovf1),
        .busy(busy1), .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1), .iord(iord1),
        .pc_source(pcs1), .treat_src(treat1), .epc_write(epcw1), .pc_write(pcw1),
        .mem_wr(memwr1), .cause(cause1), .done(done1), .exc_count(cnt1),
        .double_fault(df1)
    );

    assign act0 = {busy0, a0, b0, op0, iord0, pcs0, treat0, epcw0, pcw0, memwr0,
                   done0, cause0, cnt0, df0};
    assign act1 = {busy1, a1, b1, op1, iord1, pcs1, treat1, epcw1, pcw1, memwr1,
                   done1, cause1, cnt1, df1};

    // Expected output bundle from a description of the current cycle.
    function automatic obs_t mk(bit busy, bit epcw, bit iord_on, bit pcw, bit dn,
                                bit cs, logic [7:0] cnt, bit df);
        obs_t o;
        o       = '0;
        o.busy  = busy;
        o.epcw  = epcw;
        o.b     = epcw ? 4'd1 : 4'd0;
        o.op    = epcw ? 3'd2 : 3'd0;
        o.iord  = iord_on ? 4'd2 : 4'd0;
        o.pcw   = pcw;
        o.pcs   = pcw ? 4'd3 : 4'd0;
        o.treat = pcw ? cs : 1'b0;
        o.done  = dn;
        o.cause = cs;
        o.cnt   = cnt;
        o.df    = df;
        return o;
    endfunction

    function automatic obs_t model_obs(int i);
        int kk = k[i];
        int l  = lat[i];
        return mk(kk > 0, kk == 1, (kk >= 2) && (kk <= 3 + l), kk == 3 + l,
                  kk == 4 + l, cause_m[i] != 0, 8'(cnt_m[i]), df_m[i] != 0);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            k[i] = 0; cause_m[i] = 0; cnt_m[i] = 0; df_m[i] = 0;
        end
    endtask

    task automatic model_edge(int i, bit opc, bit ovf);
        if (k[i] == 0) begin
            if (opc || ovf) begin
                k[i]       = 1;
                cause_m[i] = opc ? 0 : 1;
            end
        end else begin
            if (opc || ovf) df_m[i] = 1;
            if (k[i] == 4 + lat[i]) begin
                k[i] = 0;
            end else begin
                k[i] = k[i] + 1;
                if (k[i] == 4 + lat[i] && cnt_m[i] < 255) cnt_m[i] = cnt_m[i] + 1;
            end
        end
    endtask

    task automatic chk(string nm, int inst, obs_t got, obs_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h required %h", nm, inst, got, exp);
        end
    endtask

    task automatic chk_int(string nm, int got, int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", nm, got, exp);
        end
    endtask

    task automatic check_model(string nm);
        chk(nm, 0, act0, model_obs(0));
        chk(nm, 1, act1, model_obs(1));
    endtask

    // One clock: drive at negedge, update model at posedge, sample 1 later.
    task automatic step(bit o0, bit v0, bit o1, bit v1, string nm);
        @(negedge clock);
        opc0 = o0; ovf0 = v0; opc1 = o1; ovf1 = v1;
        @(posedge clock);
        if (!reset) begin
            model_edge(0, o0, v0);
            model_edge(1, o1, v1);
        end
        #1;
        check_model(nm);
    endtask

    vec_t tbl[12];
    int   n_busy;
    int   pcw_cyc;
    int   treat_at_load;

    initial begin
        lat[0] = 0;
        lat[1] = 1;
        model_reset();

        // Directed rows for the MEM_LAT=1 instance, starting from reset.
        tbl[0]  = '{0, 1, mk(1, 1, 0, 0, 0, 1, 8'd0, 0)};  // EPC, overflow
        tbl[1]  = '{0, 0, mk(1, 0, 1, 0, 0, 1, 8'd0, 0)};  // FETCH
        tbl[2]  = '{1, 0, mk(1, 0, 1, 0, 0, 1, 8'd0, 1)};  // WAIT, opc dropped
        tbl[3]  = '{0, 0, mk(1, 0, 1, 1, 0, 1, 8'd0, 1)};  // LOAD, treat=1
        tbl[4]  = '{0, 0, mk(1, 0, 0, 0, 1, 1, 8'd1, 1)};  // DONE
        tbl[5]  = '{0, 0, mk(0, 0, 0, 0, 0, 1, 8'd1, 1)};  // IDLE, cause held
        tbl[6]  = '{1, 0, mk(1, 1, 0, 0, 0, 0, 8'd1, 1)};  // EPC, opcode
        tbl[7]  = '{0, 0, mk(1, 0, 1, 0, 0, 0, 8'd1, 1)};
        tbl[8]  = '{0, 0, mk(1, 0, 1, 0, 0, 0, 8'd1, 1)};
        tbl[9]  = '{0, 0, mk(1, 0, 1, 1, 0, 0, 8'd1, 1)};  // LOAD, treat=0
        tbl[10] = '{0, 0, mk(1, 0, 0, 0, 1, 0, 8'd2, 1)};
        tbl[11] = '{0, 0, mk(0, 0, 0, 0, 0, 0, 8'd2, 1)};

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        chk("reset_state", 0, act0, mk(0, 0, 0, 0, 0, 0, 8'd0, 0));
        chk("reset_state", 1, act1, mk(0, 0, 0, 0, 0, 0, 8'd0, 0));
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(0, 0, tbl[i].opc, tbl[i].ovf, "model_tbl");
            chk($sformatf("tbl_row%0d", i), 1, act1, tbl[i].exp);
        end

        // Asynchronous reset in the middle of WAIT.
        step(0, 0, 0, 1, "pre_rst_epc");
        step(0, 0, 0, 0, "pre_rst_fetch");
        step(0, 0, 0, 0, "pre_rst_wait");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_reset", 1, act1, mk(0, 0, 0, 0, 0, 0, 8'd0, 0));
        check_model("async_reset_model");
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        step(0, 0, 0, 0, "post_reset");
        chk("post_reset_idle", 1, act1, mk(0, 0, 0, 0, 0, 0, 8'd0, 0));

        // Opcode path with MEM_LAT=0: busy for 4 cycles, pc_write in cycle 3.
        n_busy  = 0;
        pcw_cyc = 0;
        step(1, 0, 0, 0, "opc_lat0");
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) step(0, 0, 0, 0, "opc_lat0");
            if (busy0) n_busy++;
            if (pcw0) pcw_cyc = c;
        end
        chk_int("opc_busy_len", n_busy, 4);
        chk_int("opc_pcw_cycle", pcw_cyc, 3);

        // Simultaneous requests: opcode wins and no double fault.
        treat_at_load = 9;
        step(1, 1, 1, 1, "simul");
        for (int c = 0; c < 6; c++) begin
            step(0, 0, 0, 0, "simul");
            if (pcw1) treat_at_load = int'(treat1);
        end
        chk_int("simul_cause", int'(cause1), 0);
        chk_int("simul_treat", treat_at_load, 0);
        chk_int("simul_df", int'(df1), 0);

        // Random traffic, checked every cycle against the model.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, "random");
        end

        // Back-to-back requests until the counter saturates.
        for (int n = 0; n < 1900; n++) begin
            step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1, "saturate");
        end
        chk_int("sat_count0", int'(cnt0), 255);
        chk_int("sat_count1", int'(cnt1), 255);
        for (int n = 0; n < 30; n++) step(1, 1, 1, 1, "saturate_hold");
        chk_int("sat_hold0", int'(cnt0), 255);
        chk_int("sat_hold1", int'(cnt1), 255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
